// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter with a one-hot rotating priority pointer.
// Optional per-owner hold limit is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam int unsigned N     = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 4;

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("rr_arb4: HOLD_MAX must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // First set bit of r at or after the pointer position, wrapping 3->0; MSB = found.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [ID_W-1:0] base;
    logic [ID_W-1:0] idx;
    base    = '0;
    idx     = '0;
    rr_pick = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (p[i]) base = ID_W'(i);
    end
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = base + ID_W'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
    rotl = {v[N-2:0], v[N-1]};
  endfunction

  state_t          state_q, state_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    search_ptr_c;
  logic [ID_W:0]   pick_c;
  logic            rel_c;
  logic            force_c;
  logic            new_gnt_c;

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  // Next-state: grant from IDLE, hold while owner requests, hand over on release.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    id_d         = id_q;
    busy_d       = busy_q;
    force_c      = 1'b0;
    new_gnt_c    = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d       = hold_q;
    if (state_q == OWN) begin
      force_c = (|(req & ~gnt_q)) && (hold_q >= CNT_W'(HOLD_MAX - 1));
    end
`endif
    rel_c        = (state_q == OWN) && (!req[id_q] || force_c);
    // On release the old owner lands last in the search order.
    search_ptr_c = rel_c ? rotl(gnt_q) : ptr_q;
    pick_c       = rr_pick(req, search_ptr_c);

    case (state_q)
      IDLE: begin
        new_gnt_c = pick_c[ID_W];
      end
      OWN: begin
        if (rel_c) begin
          ptr_d     = search_ptr_c;
          new_gnt_c = pick_c[ID_W];
          if (!pick_c[ID_W]) begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (new_gnt_c) begin
      state_d = OWN;
      gnt_d   = N'(1) << pick_c[ID_W-1:0];
      id_d    = pick_c[ID_W-1:0];
      busy_d  = 1'b1;
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter restarts on each grant and saturates at HOLD_MAX.
    if (new_gnt_c) begin
      hold_d = '0;
    end else if (state_q == OWN && hold_q != CNT_W'(HOLD_MAX)) begin
      hold_d = hold_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= N'(1);
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;

endmodule
